// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - MDOp encodings (MD_NONE .. MD_MTLO, plus the reserved code)
//   - default busy latencies MULT_CYCLES / DIV_CYCLES
//   - FSM state type for the unit
//   - md_result(): HI/LO arithmetic for one completed operation
// ----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  // Returns {HI, LO} after op completes. hi/lo are the current register
  // values, returned unchanged for divide-by-zero and non-arithmetic ops.
  function automatic logic [63:0] md_result(input md_op_e      op,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] hi,
                                            input logic [31:0] lo);
    logic [63:0]        res;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa  = a;
    sb  = b;
    res = {hi, lo};
    case (op)
      // Sign-extend to 64 bits; the low 64 bits of the product are the
      // two's-complement signed product.
      MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) begin
          res = {hi, lo};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // The only signed overflow case: pin the result explicitly.
          res = {32'd0, 32'h8000_0000};
        end else begin
          res = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          res = {hi, lo};
        end else begin
          res = {a % b, a / b};
        end
      end
      default: res = {hi, lo};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the EX stage and the multiply/divide unit.
//   start  request strobe (one cycle)
//   MDOp   operation code (mips_pkg::md_op_e encoding)
//   A, B   rs / rt operands
//   busy   operation in flight
//   HI, LO architectural HI/LO registers
// master: EX-stage side (drives request), slave: the unit.
// ----------------------------------------------------------------------------
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDOp, A, B, input busy, HI, LO);
  modport slave  (input start, MDOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU capture operands and hold busy for a fixed latency,
// then write HI/LO in one step. MTHI/MTLO write directly with no busy.
// Requests arriving while busy are ignored.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears HI/LO, aborts any op)
//   mdu      mult_div_unit_if.slave: start, MDOp, A, B in; busy, HI, LO out
// All outputs are registers.
// ----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = mips_pkg::MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = mips_pkg::DIV_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mult_div_unit_if.slave        mdu
);
  import mips_pkg::*;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;
  logic [63:0]      result_s;
  md_op_e           req_op_s;

  assign req_op_s = md_op_e'(mdu.MDOp);

  // Result from the captured operands; HI/LO cannot change during RUN, so
  // passing the live registers gives the keep-old-value cases for free.
  assign result_s = md_result(op_q, a_q, b_q, hi_q, lo_q);

  // Next-state, counter and HI/LO update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu.start) begin
          case (req_op_s)
            MD_MULT, MD_MULTU: begin
              op_d    = req_op_s;
              a_d     = mdu.A;
              b_d     = mdu.B;
              cnt_d   = CNT_MULT;
              state_d = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = req_op_s;
              a_d     = mdu.A;
              b_d     = mdu.B;
              cnt_d   = CNT_DIV;
              state_d = ST_RUN;
            end
            MD_MTHI: hi_d = mdu.A;
            MD_MTLO: lo_d = mdu.A;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Counter holds N in the first busy cycle; completion on the edge
        // where it reads 1 gives exactly N busy cycles.
        if (cnt_q <= CNT_ONE) begin
          hi_d    = result_s[63:32];
          lo_d    = result_s[31:0];
          cnt_d   = CNT_ZERO;
          op_d    = MD_NONE;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State, counter, operand capture and HI/LO/busy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      op_q    <= MD_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed-vector bench. The driver pushes the hand-computed HI/LO and busy
// length of every tracked operation into a scoreboard queue; a monitor pops
// and compares each time busy falls, and checks HI/LO hold while busy.
// Reset, MTHI/MTLO and ignored-request behaviour are checked inline.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mips_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          n;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  exp_t sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if mdu_if ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; request is sampled on the next rising edge.
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int n,
                       input string name, input bit track);
    exp_t e;
    if (track) begin
      e.name = name; e.hi = eh; e.lo = el; e.n = n;
      e.old_hi = m_hi; e.old_lo = m_lo;
      sb_q.push_back(e);
      m_hi = eh;
      m_lo = el;
    end
    mdu_if.start = 1'b1;
    mdu_if.MDOp  = op;
    mdu_if.A     = a;
    mdu_if.B     = b;
    @(negedge clk);
    mdu_if.start = 1'b0;
    mdu_if.MDOp  = MD_NONE;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((mdu_if.busy === 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, {31'd0, mdu_if.busy}, 32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    bit   busy_prev;
    int   busy_cnt;
    exp_t e;
    busy_prev = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_prev = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (mdu_if.busy === 1'b1) begin
          busy_cnt++;
          if (sb_q.size() > 0) begin
            chk({sb_q[0].name, "_hold_hi"}, mdu_if.HI, sb_q[0].old_hi);
            chk({sb_q[0].name, "_hold_lo"}, mdu_if.LO, sb_q[0].old_lo);
          end
        end else if (busy_prev) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done_busy_len", 32'(busy_cnt), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk({e.name, "_hi"}, mdu_if.HI, e.hi);
            chk({e.name, "_lo"}, mdu_if.LO, e.lo);
            chk({e.name, "_busy_len"}, 32'(busy_cnt), 32'(e.n));
          end
          busy_cnt = 0;
        end
        busy_prev = (mdu_if.busy === 1'b1);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset_n = 1'b0;
    mdu_if.start = 1'b0;
    mdu_if.MDOp  = MD_NONE;
    mdu_if.A     = 32'd0;
    mdu_if.B     = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("rst_hi", mdu_if.HI, 32'd0);
    chk("rst_lo", mdu_if.LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MTHI then MTLO on the next cycle
    mdu_if.start = 1'b1; mdu_if.MDOp = MD_MTHI; mdu_if.A = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mthi_hi", mdu_if.HI, 32'hDEAD_BEEF);
    chk("mthi_lo_old", mdu_if.LO, 32'd0);
    chk("mthi_busy", {31'd0, mdu_if.busy}, 32'd0);
    mdu_if.MDOp = MD_MTLO; mdu_if.A = 32'h0000_0001;
    @(negedge clk);
    mdu_if.start = 1'b0; mdu_if.MDOp = MD_NONE;
    chk("mtlo_lo", mdu_if.LO, 32'h0000_0001);
    chk("mtlo_hi_kept", mdu_if.HI, 32'hDEAD_BEEF);
    chk("mtlo_busy", {31'd0, mdu_if.busy}, 32'd0);
    m_hi = 32'hDEAD_BEEF;
    m_lo = 32'h0000_0001;

    // Reset during busy cycle 3 of a MULT
    issue(MD_MULT, 32'd5, 32'd7, 32'd0, 32'd0, 0, "rst_mult", 1'b0);
    chk("rst_mult_busy1", {31'd0, mdu_if.busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("midrst_hi", mdu_if.HI, 32'd0);
    chk("midrst_lo", mdu_if.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (8) @(negedge clk);
    chk("postrst_busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("postrst_hi", mdu_if.HI, 32'd0);
    chk("postrst_lo", mdu_if.LO, 32'd0);

    // Arithmetic vectors; DIVU issued back-to-back in the first idle cycle
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult", 1'b1);
    wait_idle("mult");
    @(negedge clk);
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, "multu", 1'b1);
    wait_idle("multu");
    @(negedge clk);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div", 1'b1);
    wait_idle("div");
    issue(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu_b2b", 1'b1);
    wait_idle("divu_b2b");
    @(negedge clk);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_ovf", 1'b1);
    wait_idle("div_ovf");
    @(negedge clk);

    // Divide by zero keeps HI/LO written by MTHI/MTLO
    mdu_if.start = 1'b1; mdu_if.MDOp = MD_MTHI; mdu_if.A = 32'h0000_1234;
    @(negedge clk);
    mdu_if.MDOp = MD_MTLO; mdu_if.A = 32'h0000_5678;
    @(negedge clk);
    mdu_if.start = 1'b0; mdu_if.MDOp = MD_NONE;
    chk("mt_hi_1234", mdu_if.HI, 32'h0000_1234);
    chk("mt_lo_5678", mdu_if.LO, 32'h0000_5678);
    m_hi = 32'h0000_1234;
    m_lo = 32'h0000_5678;
    issue(MD_DIVU, 32'h0000_0099, 32'd0, 32'h0000_1234, 32'h0000_5678, 10, "divu_by0", 1'b1);
    wait_idle("divu_by0");
    @(negedge clk);

    // DIV request at busy cycle 2 of a MULT is ignored
    issue(MD_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5, "mult_ign", 1'b1);
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.MDOp = MD_DIV; mdu_if.A = 32'd100; mdu_if.B = 32'd3;
    @(negedge clk);
    mdu_if.start = 1'b0; mdu_if.MDOp = MD_NONE;
    wait_idle("mult_ign");
    repeat (3) begin
      @(negedge clk);
      chk("ignored_div_busy", {31'd0, mdu_if.busy}, 32'd0);
    end

    // Reserved op code does nothing
    issue(MD_RSVD, 32'hAAAA_AAAA, 32'd1, 32'd0, 32'd0, 0, "rsvd", 1'b0);
    chk("rsvd_busy", {31'd0, mdu_if.busy}, 32'd0);
    chk("rsvd_hi", mdu_if.HI, m_hi);
    chk("rsvd_lo", mdu_if.LO, m_lo);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
